// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the data-memory interface.
// Accepts one RV32I load/store at a time and models a word-organised RAM
// with LATENCY wait states. Bytes are stored little-endian.
//
// Handshakes (both channels): a transfer happens on a rising clock edge
// where valid && ready are both 1. A requester holds valid and its payload
// stable until that edge. The responder holds rsp_rdata/rsp_err stable while
// rsp_valid is 1 and has not yet been taken.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        commit;

  logic [31:0] mem [DEPTH_WORDS];

  // Fields of the access being committed this cycle. With zero wait states the
  // commit edge is also the accept edge, so the live request is used directly.
  logic          a_we;
  logic [2:0]    a_f3;
  logic [31:0]   a_addr, a_wdata;
  logic [AW-1:0] a_idx;
  logic [1:0]    a_lane;
  logic [31:0]   a_word, a_load, a_wd;
  logic [7:0]    a_byte;
  logic [15:0]   a_half;
  logic [3:0]    a_be;
  logic          a_err;

  // Decode the committing access: legality, load extraction, store lanes.
  always_comb begin
    a_we    = we_q;
    a_f3    = f3_q;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      a_we    = req_we;
      a_f3    = req_funct3;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end
    a_idx  = a_addr[AW+1:2];
    a_lane = a_addr[1:0];
    a_word = mem[a_idx];
    a_byte = a_word[{a_lane, 3'b000} +: 8];
    a_half = a_addr[1] ? a_word[31:16] : a_word[15:0];

    a_err = 1'b0;
    if ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS)) a_err = 1'b1;
    if (a_f3[1:0] == 2'b01 && a_addr[0]) a_err = 1'b1;
    if (a_f3[1:0] == 2'b10 && a_addr[1:0] != 2'b00) a_err = 1'b1;
    if (a_we) begin
      if (a_f3[2] || a_f3[1:0] == 2'b11) a_err = 1'b1;
    end else if (a_f3 == 3'b011 || a_f3[2:1] == 2'b11) begin
      a_err = 1'b1;
    end

    a_load = 32'd0;
    case (a_f3)
      3'b000:  a_load = {{24{a_byte[7]}}, a_byte};
      3'b001:  a_load = {{16{a_half[15]}}, a_half};
      3'b010:  a_load = a_word;
      3'b100:  a_load = {24'd0, a_byte};
      3'b101:  a_load = {16'd0, a_half};
      default: a_load = 32'd0;
    endcase

    a_be = 4'b0000;
    a_wd = a_wdata;
    case (a_f3[1:0])
      2'b00: begin
        a_be = 4'b0001 << a_lane;
        a_wd = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        a_be = a_addr[1] ? 4'b1100 : 4'b0011;
        a_wd = {2{a_wdata[15:0]}};
      end
      2'b10:   a_be = 4'b1111;
      default: a_be = 4'b0000;
    endcase
  end

  // Next-state logic: accept in IDLE, count wait states, commit, drain response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      rdata_d = (a_err || a_we) ? 32'd0 : a_load;
      err_d   = a_err;
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-enable RAM write on the commit edge; reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (!rst && commit && a_we && !a_err) begin
      for (int b = 0; b < 4; b++) begin
        if (a_be[b]) mem[a_idx][8*b +: 8] <= a_wd[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array memory model, per-cycle compare
// process with an expected queue, and directed load/store vectors.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          acc_q[$];
  logic [31:0] last_rdata = 32'd0;
  logic        last_err   = 1'b0;
  logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_err = 1'b0;
  logic [31:0] prev_rdata = 32'd0;

  // Byte-addressed reference memory
  logic [7:0] mbytes [4*DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Reference access: RV32I width rules applied to a flat byte array.
  function automatic void model_access(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic err);
    int          size;
    logic        sgn;
    logic [31:0] v, t;
    rd = 32'd0;
    err = 1'b0;
    size = 0;
    sgn = 1'b0;
    case (f3)
      3'b000: begin size = 1; sgn = 1'b1; end
      3'b001: begin size = 2; sgn = 1'b1; end
      3'b010: size = 4;
      3'b100: size = 1;
      3'b101: size = 2;
      default: size = 0;
    endcase
    if (we && f3 > 3'b010) size = 0;
    if (size == 0) err = 1'b1;
    else if (addr % size != 0) err = 1'b1;
    else if (addr / 4 >= DEPTH) err = 1'b1;
    if (err) return;
    if (we) begin
      for (int k = 0; k < size; k++) begin
        t = wd >> (8 * k);
        mbytes[addr + k] = t[7:0];
      end
    end else begin
      v = 32'd0;
      for (int k = 0; k < size; k++) v = v | (32'(mbytes[addr + k]) << (8 * k));
      if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v;
    end
  endfunction

  // Compare process: every cycle out of reset, check handshake behaviour,
  // latency, stability and response contents against the model.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      acc_q.delete();
      prev_valid = 1'b0;
      prev_hs = 1'b0;
    end else begin
      check("req_ready", req_ready, (acc_q.size() == 0));
      if (prev_valid && !prev_hs) begin
        check("rsp_valid_hold", rsp_valid, 1'b1);
        if (rsp_valid) begin
          check("rsp_rdata_stable", rsp_rdata, prev_rdata);
          check("rsp_err_stable", rsp_err, prev_err);
        end
      end else if (rsp_valid) begin
        check("rsp_pending", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() != 0) check("rsp_latency", 32'(cyc - acc_q[0]), 32'(LAT + 1));
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          check("rsp_rdata", rsp_rdata, exp_q.pop_front());
          check("rsp_err", rsp_err, exp_err_q.pop_front());
        end
        last_rdata = rsp_rdata;
        last_err = rsp_err;
        if (acc_q.size() != 0) void'(acc_q.pop_front());
      end
      if (req_valid && req_ready) acc_q.push_back(cyc);
      prev_valid = rsp_valid;
      prev_hs = rsp_valid && rsp_ready;
      prev_rdata = rsp_rdata;
      prev_err = rsp_err;
    end
  end

  // Driver: present a request, hold it until accepted, queue the expectation.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    logic [31:0] er;
    logic        ee;
    int          n;
    model_access(we, f3, addr, wd, er, ee);
    exp_q.push_back(er);
    exp_err_q.push_back(ee);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    check("req_accept", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Full transaction: request then wait for the response to be taken.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    int n;
    do_req(we, f3, addr, wd);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", rsp_err, 1'b0);

    // Basic store/load
    run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_err", last_err, 1'b0);
    run(1'b0, 3'b010, 32'h10, 32'd0);
    check("lw_0x10", last_rdata, 32'hDEADBEEF);

    // Sign and zero extension
    run(1'b0, 3'b000, 32'h13, 32'd0);
    check("lb_0x13", last_rdata, 32'hFFFFFFDE);
    run(1'b0, 3'b100, 32'h13, 32'd0);
    check("lbu_0x13", last_rdata, 32'h000000DE);
    run(1'b0, 3'b001, 32'h10, 32'd0);
    check("lh_0x10", last_rdata, 32'hFFFFBEEF);
    run(1'b0, 3'b101, 32'h12, 32'd0);
    check("lhu_0x12", last_rdata, 32'h0000DEAD);

    // Byte-lane merge
    run(1'b1, 3'b000, 32'h11, 32'h000000AA);
    run(1'b0, 3'b010, 32'h10, 32'd0);
    check("sb_merge", last_rdata, 32'hDEADAAEF);

    // Half store into upper lanes
    run(1'b1, 3'b010, 32'h14, 32'h00000000);
    run(1'b1, 3'b001, 32'h16, 32'hABCD1234);
    run(1'b0, 3'b010, 32'h14, 32'd0);
    check("sh_upper", last_rdata, 32'h12340000);

    // Errors
    run(1'b1, 3'b010, 32'h12, 32'h55555555);
    check("sw_misalign_err", last_err, 1'b1);
    run(1'b0, 3'b010, 32'h10, 32'd0);
    check("after_bad_sw", last_rdata, 32'hDEADAAEF);
    run(1'b0, 3'b001, 32'h21, 32'd0);
    check("lh_misalign_err", last_err, 1'b1);
    check("lh_misalign_rdata", last_rdata, 32'd0);
    run(1'b0, 3'b010, 32'(4 * DEPTH), 32'd0);
    check("lw_range_err", last_err, 1'b1);
    run(1'b0, 3'b011, 32'h10, 32'd0);
    check("ld_f3_011_err", last_err, 1'b1);
    run(1'b1, 3'b100, 32'h10, 32'h77777777);
    check("st_f3_100_err", last_err, 1'b1);
    run(1'b0, 3'b010, 32'h10, 32'd0);
    check("after_bad_st", last_rdata, 32'hDEADAAEF);

    // Top word of the RAM
    run(1'b1, 3'b010, 32'(4 * DEPTH - 4), 32'h11223344);
    run(1'b0, 3'b000, 32'(4 * DEPTH - 1), 32'd0);
    check("lb_top", last_rdata, 32'h00000011);
    check("lb_top_err", last_err, 1'b0);

    // Backpressure
    rsp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_valid", rsp_valid, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_valid_hold", rsp_valid, 1'b1);
      check("bp_rdata", rsp_rdata, 32'hDEADAAEF);
      check("bp_err", rsp_err, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", rsp_valid, 1'b1);
    @(negedge clk);
    check("bp_req_ready_after", req_ready, 1'b1);
    check("bp_valid_after", rsp_valid, 1'b0);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset in WAIT drops the store
    run(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h40;
    req_wdata = 32'h12345678;
    @(negedge clk);
    check("rst_accept_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_no_rsp", rsp_valid, 1'b0);
    end
    run(1'b0, 3'b010, 32'h40, 32'd0);
    check("rst_store_dropped", last_rdata, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
